ram_copy_engine: RTL and testbench

- Single-clock command-driven initiator for the team's dual-port RAM.
- Drives one RAM port as a reader and the other as a writer, and copies a block of words from a source range to a destination range.
- In fill mode it writes a constant pattern instead of copying.
- Sits between a control/CPU-side command source and the RAM's two ports. Matches the RAM's one-cycle registered read latency.

---
 rtl/ram_copy_engine_pkg.sv | 25 ++
 rtl/ram_copy_engine_if.sv | 38 +++
 rtl/ram_copy_engine.sv | 150 +++++++++++++++
 tb/tb_ram_copy_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_copy_engine_pkg.sv
// rtl/ram_copy_engine_pkg.sv - shared types and constants for the RAM copy engine
package ram_copy_engine_pkg;

  localparam int CMD_DATA_WIDTH = 8;
  localparam int CMD_ADDR_WIDTH = 8;

  // Registered read latency of the attached dual-port RAM.
  localparam int READ_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FILL
  } state_t;

  typedef struct packed {
    logic                      fill;
    logic [CMD_ADDR_WIDTH-1:0] src;
    logic [CMD_ADDR_WIDTH-1:0] dst;
    logic [CMD_ADDR_WIDTH:0]   len;
    logic [CMD_DATA_WIDTH-1:0] pattern;
  } cmd_t;

endpackage

// File: rtl/ram_copy_engine_if.sv
// rtl/ram_copy_engine_if.sv - command and RAM-port bundle of the copy engine
interface ram_copy_engine_if
  import ram_copy_engine_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DATA_WIDTH,
  parameter int ADDR_WIDTH = CMD_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_fill;
  logic [ADDR_WIDTH-1:0] cmd_src;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic [DATA_WIDTH-1:0] cmd_pattern;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_we;

  logic                  busy;
  logic                  done;

  // Command source plus RAM side of the system.
  modport master (
    output cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, rd_q,
    input  cmd_ready, rd_addr, wr_addr, wr_data, wr_we, busy, done
  );

  // The engine itself.
  modport slave (
    input  cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, rd_q,
    output cmd_ready, rd_addr, wr_addr, wr_data, wr_we, busy, done
  );

endinterface

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - block copy / pattern fill initiator for a dual-port RAM
// Port A of the RAM is read through rd_*, port B is written through wr_*.
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DATA_WIDTH,
  parameter int ADDR_WIDTH = CMD_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ram_copy_engine_if.slave bus
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  state_t                state;
  cmd_t                  cmd_in;
  logic                  accept;
  logic                  issue_rd;

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_WIDTH-1:0]  rd_left;
  logic [CNT_WIDTH-1:0]  wr_left;
  logic [DATA_WIDTH-1:0] pattern_q;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_we_q;
  logic                  busy_q;
  logic                  done_q;

  // Bit 0 marks a read issued this cycle; the top bit marks rd_q valid now.
  logic [READ_LATENCY:0] vld_pipe;

  assign cmd_in = '{
    fill:    bus.cmd_fill,
    src:     bus.cmd_src,
    dst:     bus.cmd_dst,
    len:     bus.cmd_len,
    pattern: bus.cmd_pattern
  };

  assign accept   = bus.cmd_valid && (state == IDLE);
  assign issue_rd = (accept && !cmd_in.fill && (cmd_in.len != '0)) ||
                    ((state == READ) && (rd_left != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rd_left   <= '0;
      wr_left   <= '0;
      pattern_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      done_q   <= 1'b0;
      wr_we_q  <= 1'b0;
      vld_pipe <= {vld_pipe[READ_LATENCY-1:0], issue_rd};

      // Copy write stage: RAM data for the oldest outstanding read is on rd_q.
      if (vld_pipe[READ_LATENCY]) begin
        wr_we_q   <= 1'b1;
        wr_addr_q <= wr_ptr;
        wr_data_q <= bus.rd_q;
        wr_ptr    <= wr_ptr + 1'b1;
        wr_left   <= wr_left - 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            pattern_q <= cmd_in.pattern;
            if (cmd_in.len == '0) begin
              done_q <= 1'b1;
            end else if (cmd_in.fill) begin
              state     <= FILL;
              busy_q    <= 1'b1;
              wr_we_q   <= 1'b1;
              wr_addr_q <= cmd_in.dst;
              wr_data_q <= cmd_in.pattern;
              wr_ptr    <= cmd_in.dst + 1'b1;
              wr_left   <= cmd_in.len - 1'b1;
            end else begin
              state     <= READ;
              busy_q    <= 1'b1;
              rd_addr_q <= cmd_in.src;
              rd_ptr    <= cmd_in.src + 1'b1;
              rd_left   <= cmd_in.len - 1'b1;
              wr_ptr    <= cmd_in.dst;
              wr_left   <= cmd_in.len;
            end
          end
        end

        READ: begin
          if (rd_left != '0) begin
            rd_addr_q <= rd_ptr;
            rd_ptr    <= rd_ptr + 1'b1;
            rd_left   <= rd_left - 1'b1;
          end else begin
            state <= DRAIN;
          end
        end

        // wr_left reaches zero on the edge that issues the last write.
        DRAIN: begin
          if (wr_left == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        FILL: begin
          if (wr_left != '0) begin
            wr_we_q   <= 1'b1;
            wr_addr_q <= wr_ptr;
            wr_data_q <= pattern_q;
            wr_ptr    <= wr_ptr + 1'b1;
            wr_left   <= wr_left - 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_we     = wr_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - directed self-checking bench for ram_copy_engine
// A behavioural dual-port RAM with one-cycle registered read sits on the engine's ports.
module tb_ram_copy_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];
  logic       mem_clr;
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  logic [7:0] src_tbl [0:7] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
  logic [7:0] fill_wa [0:2] = '{8'hFE, 8'hFF, 8'h00};

  ram_copy_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.wr_we) mem[bus.wr_addr] <= bus.wr_data;
    bus.rd_q <= mem[bus.rd_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic issue(input logic fill, input logic [7:0] src, input logic [7:0] dst,
                       input logic [8:0] len, input logic [7:0] pat);
    chk("ready_at_issue", 32'(bus.cmd_ready), 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_fill    = fill;
    bus.cmd_src     = src;
    bus.cmd_dst     = dst;
    bus.cmd_len     = len;
    bus.cmd_pattern = pat;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  initial begin
    logic we_e;
    int   we_cnt;
    int   done_cnt;
    int   done_cyc;
    int   mem_bad;

    bus.cmd_valid   = 1'b0;
    bus.cmd_fill    = 1'b0;
    bus.cmd_src     = 8'h00;
    bus.cmd_dst     = 8'h00;
    bus.cmd_len     = 9'h000;
    bus.cmd_pattern = 8'h00;
    pre_we   = 1'b0;
    pre_addr = 8'h00;
    pre_data = 8'h00;
    mem_clr  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;

    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_wr_we",   32'(bus.wr_we), 0);
    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_done",    32'(bus.done), 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.cmd_ready), 1);

    for (int i = 0; i < 8; i++) poke(8'h10 + 8'(i), src_tbl[i]);

    // Copy 0x10..0x13 -> 0x80..0x83.
    issue(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      we_e = (c >= 3 && c <= 6);
      chk($sformatf("cp_we_c%0d", c), 32'(bus.wr_we), 32'(we_e));
      if (we_e) begin
        chk($sformatf("cp_wa_c%0d", c), 32'(bus.wr_addr), 32'h80 + c - 3);
        chk($sformatf("cp_wd_c%0d", c), 32'(bus.wr_data), 32'(src_tbl[c-3]));
      end
      if (c <= 4) chk($sformatf("cp_ra_c%0d", c), 32'(bus.rd_addr), 32'h10 + c - 1);
      chk($sformatf("cp_busy_c%0d", c), 32'(bus.busy), 32'(c <= 6));
      chk($sformatf("cp_done_c%0d", c), 32'(bus.done), 32'(c == 7));
      tick();
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("cp_mem_%0d", i), 32'(mem[8'h80 + 8'(i)]), 32'(src_tbl[i]));

    // Fill with wrap past the top address; rd_addr must hold the last read address.
    issue(1'b1, 8'h44, 8'hFE, 9'd3, 8'h5A);
    for (int c = 1; c <= 5; c++) begin
      we_e = (c <= 3);
      chk($sformatf("fl_we_c%0d", c), 32'(bus.wr_we), 32'(we_e));
      if (we_e) begin
        chk($sformatf("fl_wa_c%0d", c), 32'(bus.wr_addr), 32'(fill_wa[c-1]));
        chk($sformatf("fl_wd_c%0d", c), 32'(bus.wr_data), 32'h5A);
      end
      chk($sformatf("fl_ra_c%0d", c), 32'(bus.rd_addr), 32'h13);
      chk($sformatf("fl_busy_c%0d", c), 32'(bus.busy), 32'(c <= 3));
      chk($sformatf("fl_done_c%0d", c), 32'(bus.done), 32'(c == 4));
      tick();
    end
    chk("fl_mem_fe", 32'(mem[8'hFE]), 32'h5A);
    chk("fl_mem_ff", 32'(mem[8'hFF]), 32'h5A);
    chk("fl_mem_00", 32'(mem[8'h00]), 32'h5A);

    // Zero-length copy.
    issue(1'b0, 8'h10, 8'h50, 9'd0, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("z_we_c%0d", c), 32'(bus.wr_we), 0);
      chk($sformatf("z_busy_c%0d", c), 32'(bus.busy), 0);
      chk($sformatf("z_done_c%0d", c), 32'(bus.done), 32'(c == 1));
      chk($sformatf("z_ready_c%0d", c), 32'(bus.cmd_ready), 1);
      tick();
    end

    // Back-to-back: fill accepted in the done cycle of a two-word copy.
    issue(1'b0, 8'h10, 8'h40, 9'd2, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      we_e = (c >= 3);
      chk($sformatf("bb_we_c%0d", c), 32'(bus.wr_we), 32'(we_e));
      if (we_e) chk($sformatf("bb_wa_c%0d", c), 32'(bus.wr_addr), 32'h40 + c - 3);
      chk($sformatf("bb_done_c%0d", c), 32'(bus.done), 0);
      tick();
    end
    chk("bb_done_c5", 32'(bus.done), 1);
    issue(1'b1, 8'h00, 8'h20, 9'd2, 8'h11);
    chk("bb2_we_c1", 32'(bus.wr_we), 1);
    chk("bb2_wa_c1", 32'(bus.wr_addr), 32'h20);
    chk("bb2_wd_c1", 32'(bus.wr_data), 32'h11);
    tick();
    chk("bb2_wa_c2", 32'(bus.wr_addr), 32'h21);
    tick();
    chk("bb2_done_c3", 32'(bus.done), 1);
    chk("bb2_we_c3", 32'(bus.wr_we), 0);
    tick();
    chk("bb_mem_40", 32'(mem[8'h40]), 32'hA1);
    chk("bb_mem_41", 32'(mem[8'h41]), 32'hB2);
    chk("bb_mem_21", 32'(mem[8'h21]), 32'h11);

    // cmd_valid held with scrambled fields while busy.
    issue(1'b0, 8'h10, 8'h60, 9'd4, 8'h00);
    bus.cmd_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      bus.cmd_fill    = 1'b1;
      bus.cmd_src     = 8'h77;
      bus.cmd_dst     = 8'hAA + 8'(c);
      bus.cmd_len     = 9'h0FF;
      bus.cmd_pattern = 8'hEE;
      we_e = (c >= 3);
      chk($sformatf("hv_ready_c%0d", c), 32'(bus.cmd_ready), 0);
      chk($sformatf("hv_we_c%0d", c), 32'(bus.wr_we), 32'(we_e));
      if (we_e) begin
        chk($sformatf("hv_wa_c%0d", c), 32'(bus.wr_addr), 32'h60 + c - 3);
        chk($sformatf("hv_wd_c%0d", c), 32'(bus.wr_data), 32'(src_tbl[c-3]));
      end
      tick();
    end
    chk("hv_ready_c7", 32'(bus.cmd_ready), 1);
    chk("hv_done_c7", 32'(bus.done), 1);
    bus.cmd_fill = 1'b0;
    bus.cmd_len  = 9'd0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("hv_len0_done", 32'(bus.done), 1);
    chk("hv_len0_we", 32'(bus.wr_we), 0);
    chk("hv_len0_busy", 32'(bus.busy), 0);
    tick();
    chk("hv_mem_63", 32'(mem[8'h63]), 32'hD4);

    // Reset in cycle 4 of an 8-word copy.
    issue(1'b0, 8'h10, 8'h90, 9'd8, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("rs_we_c%0d", c), 32'(bus.wr_we), 32'(c >= 3));
      if (c < 4) tick();
    end
    rst = 1'b0;
    #1;
    chk("rs_now_we", 32'(bus.wr_we), 0);
    chk("rs_now_busy", 32'(bus.busy), 0);
    chk("rs_now_wa", 32'(bus.wr_addr), 0);
    chk("rs_now_wd", 32'(bus.wr_data), 0);
    chk("rs_now_ra", 32'(bus.rd_addr), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    we_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.wr_we) we_cnt++;
      if (bus.done) done_cnt++;
      tick();
    end
    chk("rs_after_we", 32'(we_cnt), 0);
    chk("rs_after_done", 32'(done_cnt), 0);
    chk("rs_after_ready", 32'(bus.cmd_ready), 1);
    chk("rs_mem_90", 32'(mem[8'h90]), 32'hA1);
    chk("rs_mem_91", 32'(mem[8'h91]), 32'h00);
    issue(1'b1, 8'h00, 8'h30, 9'd1, 8'h77);
    chk("rs_new_we", 32'(bus.wr_we), 1);
    chk("rs_new_wa", 32'(bus.wr_addr), 32'h30);
    chk("rs_new_wd", 32'(bus.wr_data), 32'h77);
    tick();
    chk("rs_new_done", 32'(bus.done), 1);
    tick();

    // Whole-memory fill, len = 256.
    issue(1'b1, 8'h00, 8'h05, 9'h100, 8'h3C);
    we_cnt   = 0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 260; c++) begin
      if (bus.wr_we) we_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 256) begin
        chk("full_busy_c256", 32'(bus.busy), 1);
        chk("full_wa_c256", 32'(bus.wr_addr), 32'h04);
      end
      tick();
    end
    chk("full_we_count", 32'(we_cnt), 256);
    chk("full_done_count", 32'(done_cnt), 1);
    chk("full_done_cycle", 32'(done_cyc), 257);
    mem_bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h3C) mem_bad++;
    chk("full_mem_bad_words", 32'(mem_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
